// File: rtl/simd_seq_pkg.sv
// Shared types and helpers for the SIMD element sequencer: state encoding
// and the element-width select decode.
package simd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Returns k with EW = MAX_WIDTH >> k, so EPW = 1 << k. The lowest set bit wins;
  // an all-zero select (or an out-of-range bit) falls back to the narrowest width.
  function automatic int sew_decode(input logic [15:0] sew, input int sew_w, input int max_shift);
    int k;
    k = max_shift;
    for (int i = 15; i >= 0; i--)
      if (i < sew_w && sew[i]) k = i;
    if (k > max_shift) k = max_shift;
    return k;
  endfunction

endpackage

// File: rtl/simd_tail_mask.sv
// Per-word bit-enable mask: the first 'active' elements of width EW are
// fully enabled, the rest of the word is zero.
module simd_tail_mask
  import simd_seq_pkg::*;
#(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int SEW_WIDTH = $clog2(MAX_WIDTH/MIN_WIDTH)+1,
  parameter int CNT_WIDTH = $clog2(MAX_WIDTH/MIN_WIDTH)+1
) (
  input  logic [SEW_WIDTH-1:0] sew,
  input  logic [CNT_WIDTH-1:0] active,
  output logic [MAX_WIDTH-1:0] mask
);

  localparam int MAX_SHIFT = $clog2(MAX_WIDTH/MIN_WIDTH);
  localparam int WORD_LOG  = $clog2(MAX_WIDTH);

  int shift;
  int ew_log;

  // Bit j belongs to element j >> log2(EW); it is enabled when that element is active.
  always_comb begin
    shift  = sew_decode(16'(sew), SEW_WIDTH, MAX_SHIFT);
    ew_log = WORD_LOG - shift;
    mask   = '0;
    for (int j = 0; j < MAX_WIDTH; j++)
      mask[j] = (32'(j) >> ew_log) < 32'(active);
  end

endmodule

// File: rtl/simd_elem_seq.sv
// SIMD element sequencer: walks a vector of vl elements one datapath word per
// beat, emitting a bit-enable mask with a tail cut at the last active element.
module simd_elem_seq
  import simd_seq_pkg::*;
#(
  parameter int MIN_WIDTH = 8,
  parameter int MAX_WIDTH = 64,
  parameter int SEW_WIDTH = $clog2(MAX_WIDTH/MIN_WIDTH)+1,
  parameter int VL_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SEW_WIDTH-1:0] req_sew,
  input  logic [VL_WIDTH-1:0]  req_vl,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_WIDTH-1:0] out_mask,
  output logic [VL_WIDTH-1:0]  out_beat,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int MAX_SHIFT = $clog2(MAX_WIDTH/MIN_WIDTH);
  localparam int CNT_WIDTH = MAX_SHIFT + 1;
  localparam int IW        = VL_WIDTH + 1;

  seq_state_e           state;
  logic [SEW_WIDTH-1:0] sew_q;
  logic [VL_WIDTH-1:0]  vl_q;
  logic [VL_WIDTH-1:0]  beat;
  logic [IW-1:0]        epw, base, rem;
  logic                 last;
  logic [CNT_WIDTH-1:0] active;
  logic [MAX_WIDTH-1:0] mask;
  int                   shift;

  // Element indices carry one extra bit so the final word of a full-length vector does not wrap.
  always_comb begin
    shift  = sew_decode(16'(sew_q), SEW_WIDTH, MAX_SHIFT);
    epw    = IW'(1) << shift;
    base   = IW'(beat) << shift;
    rem    = IW'(vl_q) - base;
    last   = rem <= epw;
    active = last ? CNT_WIDTH'(rem) : CNT_WIDTH'(epw);
  end

  simd_tail_mask #(
    .MIN_WIDTH(MIN_WIDTH),
    .MAX_WIDTH(MAX_WIDTH),
    .SEW_WIDTH(SEW_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_tail_mask (
    .sew   (sew_q),
    .active(active),
    .mask  (mask)
  );

  assign out_mask = out_valid ? mask : '0;
  assign out_last = out_valid & last;
  assign out_beat = beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sew_q     <= '0;
      vl_q      <= '0;
      beat      <= '0;
      req_ready <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      beat      <= '0;
      req_ready <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            sew_q     <= req_sew;
            vl_q      <= req_vl;
            beat      <= '0;
            req_ready <= 1'b0;
            if (req_vl != '0) begin
              state     <= RUN;
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (out_valid && out_ready) begin
            if (last) begin
              state     <= DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              beat <= beat + VL_WIDTH'(1);
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/simd_elem_seq.md
SIMD_ELEM_SEQ -- requirements
Module: simd_elem_seq

Interface
REQ-001 SHALL have parameter MIN_WIDTH, default 8: narrowest element width in bits.
REQ-002 SHALL have parameter MAX_WIDTH, default 64: datapath word width in bits.
REQ-003 SHALL have parameter SEW_WIDTH, default $clog2(MAX_WIDTH/MIN_WIDTH)+1: width of the SEW select.
REQ-004 SHALL have parameter VL_WIDTH, default 8: width of the vector-length field.
REQ-005 SHALL have the following ports, one per line (name, direction, width, meaning):
 clk  in  1  single clock; all state updates on rising edge.
 rst  in  1  reset, asynchronous, active-high.
 req_valid  in  1  new sequencing request.
 req_ready  out  1  sequencer can accept a request.
 req_sew  in  SEW_WIDTH  element-width select; bit k means width MAX_WIDTH>>k.
 req_vl  in  VL_WIDTH  number of active elements.
 flush  in  1  abort the current request.
 out_valid  out  1  beat mask valid.
 out_ready  in  1  consumer accepts beat.
 out_mask  out  MAX_WIDTH  bit-enable mask for the current datapath word.
 out_beat  out  VL_WIDTH  index of the current word, starting at 0.
 out_last  out  1  current beat is the final beat.
 busy  out  1  request in progress.
 done  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL decode SEW by priority: the lowest set bit k gives element width EW=MAX_WIDTH>>k; all-zero gives EW=MIN_WIDTH; EPW=MAX_WIDTH/EW elements per word.
REQ-007 SHALL use states IDLE, RUN and DONE; req_ready=1 only in IDLE; busy=1 in RUN.
REQ-008 SHALL, on a req_valid&&req_ready handshake, latch sew and vl, reset the beat counter to 0, and go to RUN when vl>0 or to DONE when vl=0.
REQ-009 SHALL assert out_valid in RUN only; the first beat is visible in the cycle after request acceptance.
REQ-010 SHALL, for beat b, set element i (0..EPW-1) active iff b*EPW+i < vl; an active element drives out_mask bits [i*EW +: EW] to 1, all other bits are 0.
REQ-011 SHALL total ceil(vl/EPW) beats; out_last=1 iff (b+1)*EPW >= vl.
REQ-012 SHALL hold out_mask, out_beat and out_last stable while out_valid&&!out_ready.
REQ-013 SHALL increment the beat counter on out_valid&&out_ready when not last; on the last handshake it SHALL go to DONE.
REQ-014 SHALL in DONE assert done for exactly one cycle, then go to IDLE; done is never asserted in any other state.
REQ-015 SHALL treat flush as synchronous, highest priority, and effective in any state: next state IDLE, out_valid=0 next cycle, no done pulse.
REQ-016 SHALL ignore req_* inputs outside IDLE.
REQ-017 SHALL compute element indices at VL_WIDTH+1 bits so the word containing element 2^VL_WIDTH-1 does not wrap.

Reset
REQ-018 SHALL, while rst=1, force state IDLE, beat counter 0, latched sew/vl 0, and outputs out_valid=0, done=0, busy=0, out_last=0, out_mask=0, out_beat=0, req_ready=0.
REQ-019 SHALL, after rst deasserts, drive req_ready=1 from the first clock edge.
REQ-020 SHALL discard an in-flight request on mid-operation reset, with no done pulse.

Structure
REQ-021 SHALL take the state enum and the SEW-decode function from shared package simd_seq_pkg.
REQ-022 SHALL place the per-word mask generation in combinational sub-module simd_tail_mask (inputs: sew, active-element count 0..EPW; output: MAX_WIDTH mask); all sequencing stays in simd_elem_seq.

Verification
REQ-023 SHALL cover sew=4'b0010 (EW=32), vl=3, out_ready=1: beat0 mask=64'hFFFF_FFFF_FFFF_FFFF, last=0; beat1 mask=64'h0000_0000_FFFF_FFFF, last=1; done one cycle later.
REQ-024 SHALL cover sew=0 (EW=8), vl=10: beat0 mask all ones; beat1 mask=64'h0000_0000_0000_FFFF, last=1.
REQ-025 SHALL cover vl=0: no out_valid; done pulses the cycle after acceptance; req_ready returns the cycle after that.
REQ-026 SHALL cover sew=4'b0001, vl=4, with out_ready low for 3 cycles on beat1: outputs stay stable, then 4 beats total, each with an all-ones mask.
REQ-027 SHALL cover flush on beat1 of a 4-beat request: out_valid=0 next cycle, no done, req_ready=1; the next request sequences correctly.
REQ-028 SHALL cover rst asserted mid-RUN: all outputs go to reset values asynchronously, without waiting for a clock edge.
